// File: rtl/hall_sensor_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hall_sensor_conditioner                                       |
// | Purpose  : Synchronise and glitch-filter three raw Hall inputs, flag     |
// |            invalid codes, detect commutation steps and direction, and    |
// |            measure the step period with stall detection.                 |
// | Options  : HALL_SEQ_CHECK_EN - flag non-adjacent valid->valid jumps      |
// |            in a sticky seq_err instead of treating them as steps.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hall_sensor_conditioner #(
  parameter int FILT_LEN    = 4,
  parameter int PERIOD_W    = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          hall_in,
  input  logic                seq_err_clr,
  output logic                sa,
  output logic                sb,
  output logic                sc,
  output logic                hall_err,
  output logic                step,
  output logic                dir_obs,
  output logic [PERIOD_W-1:0] period,
  output logic                period_vld,
  output logic                stalled,
  output logic                seq_err
);

  localparam int                    FCNT_W      = $clog2(FILT_LEN);
  localparam logic [FCNT_W-1:0]     FCNT_MAX    = FCNT_W'(FILT_LEN - 1);
  localparam logic [PERIOD_W-1:0]   PCNT_MAX    = '1;
  localparam logic [PERIOD_W-1:0]   TIMEOUT_VAL = PERIOD_W'(TIMEOUT_CYC);

  // Forward rotation order: 100 -> 110 -> 010 -> 011 -> 001 -> 101 -> 100
  function automatic logic [2:0] fwd_succ(input logic [2:0] c);
    case (c)
      3'b100:  fwd_succ = 3'b110;
      3'b110:  fwd_succ = 3'b010;
      3'b010:  fwd_succ = 3'b011;
      3'b011:  fwd_succ = 3'b001;
      3'b001:  fwd_succ = 3'b101;
      3'b101:  fwd_succ = 3'b100;
      default: fwd_succ = 3'b000;
    endcase
  endfunction

  function automatic logic code_valid(input logic [2:0] c);
    code_valid = (c != 3'b000) && (c != 3'b111);
  endfunction

  logic [2:0]          sync1_q, sync1_d, sync_q, sync_d, cand_q, cand_d, stable_q, stable_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                step_q, step_d, dir_q, dir_d, period_vld_q, period_vld_d;
  logic                stalled_q, stalled_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d, period_q, period_d, pcnt_inc;
  logic                accept, both_valid, is_fwd, is_rev, is_jump, step_ev, timeout_hit;

  // Synchroniser and stability filter; a new code must still be present on
  // sync when it is committed, so pulses shorter than FILT_LEN+1 are dropped.
  always_comb begin
    sync1_d = hall_in;
    sync_d  = sync1_q;
    cand_d  = sync_q;
    if (sync_q != cand_q) begin
      fcnt_d = '0;
    end else if (fcnt_q != FCNT_MAX) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end else begin
      fcnt_d = fcnt_q;
    end
    accept   = (fcnt_q == FCNT_MAX) && (sync_q == cand_q) && (cand_q != stable_q);
    stable_d = accept ? cand_q : stable_q;
  end

  // Classify the committed transition old (stable_q) -> new (cand_q)
  always_comb begin
    both_valid = code_valid(stable_q) && code_valid(cand_q);
    is_fwd     = accept && both_valid && (cand_q == fwd_succ(stable_q));
    is_rev     = accept && both_valid && (stable_q == fwd_succ(cand_q));
    is_jump    = accept && both_valid && !is_fwd && !is_rev;
  end

`ifdef HALL_SEQ_CHECK_EN
  logic seq_err_q, seq_err_d;

  assign step_ev = is_fwd | is_rev;

  // Sticky jump flag; a new jump beats a simultaneous clear
  always_comb begin
    if (is_jump) begin
      seq_err_d = 1'b1;
    end else if (seq_err_clr) begin
      seq_err_d = 1'b0;
    end else begin
      seq_err_d = seq_err_q;
    end
  end

  // Sequence-error flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  logic unused_seq_err_clr;

  assign step_ev            = is_fwd | is_rev | is_jump;
  assign seq_err            = 1'b0;
  assign unused_seq_err_clr = seq_err_clr;
`endif

  // Step pulse, direction, period counter and stall tracking
  always_comb begin
    step_d = step_ev;
    dir_d  = dir_q;
    if (is_fwd) begin
      dir_d = 1'b0;
    end else if (is_rev) begin
      dir_d = 1'b1;
    end
    pcnt_inc     = (pcnt_q == PCNT_MAX) ? pcnt_q : pcnt_q + PERIOD_W'(1);
    timeout_hit  = !step_ev && (pcnt_inc == TIMEOUT_VAL);
    pcnt_d       = step_ev ? PERIOD_W'(1) : pcnt_inc;
    period_d     = period_q;
    period_vld_d = 1'b0;
    stalled_d    = stalled_q;
    if (step_ev) begin
      stalled_d = 1'b0;
      // The first step after a stall has no reference edge to measure from
      if (!stalled_q) begin
        period_d     = pcnt_q;
        period_vld_d = 1'b1;
      end
    end else if (timeout_hit) begin
      stalled_d = 1'b1;
      period_d  = '1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 3'b000;
      sync_q       <= 3'b000;
      cand_q       <= 3'b000;
      stable_q     <= 3'b000;
      fcnt_q       <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      pcnt_q       <= '0;
      period_q     <= '1;
      period_vld_q <= 1'b0;
      stalled_q    <= 1'b1;
    end else begin
      sync1_q      <= sync1_d;
      sync_q       <= sync_d;
      cand_q       <= cand_d;
      stable_q     <= stable_d;
      fcnt_q       <= fcnt_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      pcnt_q       <= pcnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      stalled_q    <= stalled_d;
    end
  end

  assign sa         = stable_q[2];
  assign sb         = stable_q[1];
  assign sc         = stable_q[0];
  assign hall_err   = !code_valid(stable_q);
  assign step       = step_q;
  assign dir_obs    = dir_q;
  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign stalled    = stalled_q;

endmodule
`default_nettype wire

// File: tb/tb_hall_sensor_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hall_sensor_conditioner                                    |
// | Purpose  : Scoreboard bench for hall_sensor_conditioner; directed Hall   |
// |            code sequences push expected output events, a negedge        |
// |            monitor pops and compares whenever the outputs change.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_hall_sensor_conditioner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  hall_in = 3'b100;
  logic        seq_err_clr = 1'b0;
  logic        sa, sb, sc, hall_err, step, dir_obs, period_vld, stalled, seq_err;
  logic [15:0] period;

  hall_sensor_conditioner #(
    .FILT_LEN    (4),
    .PERIOD_W    (16),
    .TIMEOUT_CYC (1000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hall_in     (hall_in),
    .seq_err_clr (seq_err_clr),
    .sa          (sa),
    .sb          (sb),
    .sc          (sc),
    .hall_err    (hall_err),
    .step        (step),
    .dir_obs     (dir_obs),
    .period      (period),
    .period_vld  (period_vld),
    .stalled     (stalled),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  code;
    logic        herr;
    logic        step;
    logic        dir;
    logic        pv;
    logic [15:0] period;
    logic        stalled;
    logic        serr;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  t_last = 0;

  // Hall latency from a drive just after edge N: output changes at edge N+7
  localparam int LAT = 7;

  task automatic expect_ev(input int at, input logic [2:0] code, input logic st, input logic dir,
                           input logic pv, input logic [15:0] per, input logic stl, input logic serr);
    ev_t e;
    e.cyc     = 32'(at);
    e.code    = code;
    e.herr    = (code == 3'b000) || (code == 3'b111);
    e.step    = st;
    e.dir     = dir;
    e.pv      = pv;
    e.period  = per;
    e.stalled = stl;
    e.serr    = serr;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [2:0] c, input int n);
    hall_in = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_code"},       32'({sa, sb, sc}), 32'd0);
    chk({tag, "_hall_err"},   32'(hall_err),     32'd1);
    chk({tag, "_step"},       32'(step),         32'd0);
    chk({tag, "_dir"},        32'(dir_obs),      32'd0);
    chk({tag, "_period"},     32'(period),       32'hFFFF);
    chk({tag, "_period_vld"}, 32'(period_vld),   32'd0);
    chk({tag, "_stalled"},    32'(stalled),      32'd1);
    chk({tag, "_seq_err"},    32'(seq_err),      32'd0);
  endtask

  // Monitor: any output change or pulse is one DUT event to score
  initial begin
    ev_t prev, cur, e;
    prev = '{cyc: 32'd0, code: 3'b000, herr: 1'b1, step: 1'b0, dir: 1'b0, pv: 1'b0,
             period: 16'hFFFF, stalled: 1'b1, serr: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '{cyc: 32'd0, code: 3'b000, herr: 1'b1, step: 1'b0, dir: 1'b0, pv: 1'b0,
                 period: 16'hFFFF, stalled: 1'b1, serr: 1'b0};
      end else begin
        cur = '{cyc: 32'(cyc), code: {sa, sb, sc}, herr: hall_err, step: step, dir: dir_obs,
                pv: period_vld, period: period, stalled: stalled, serr: seq_err};
        if (step || period_vld || cur.code !== prev.code || cur.herr !== prev.herr ||
            cur.dir !== prev.dir || cur.period !== prev.period ||
            cur.stalled !== prev.stalled || cur.serr !== prev.serr) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got cyc=%0d code=%b step=%b dir=%b pv=%b period=%0d stalled=%b serr=%b, none expected",
                     cur.cyc, cur.code, cur.step, cur.dir, cur.pv, cur.period, cur.stalled, cur.serr);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              bad++;
              $display("FAIL event_%0d: got cyc=%0d code=%b herr=%b step=%b dir=%b pv=%b period=%0d stalled=%b serr=%b; want cyc=%0d code=%b herr=%b step=%b dir=%b pv=%b period=%0d stalled=%b serr=%b",
                       total, cur.cyc, cur.code, cur.herr, cur.step, cur.dir, cur.pv, cur.period, cur.stalled, cur.serr,
                       e.cyc, e.code, e.herr, e.step, e.dir, e.pv, e.period, e.stalled, e.serr);
            end
          end
          prev = cur;
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [2:0] fwd_codes [5];
    logic [2:0] rev_codes [5];
    fwd_codes = '{3'b010, 3'b011, 3'b001, 3'b101, 3'b100};
    rev_codes = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("init");

    // Release with 100 held: first code accepted, still stalled, no step
    expect_ev(cyc + LAT, 3'b100, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    rst_n = 1'b1;
    hold(3'b100, 20);

    // Glitches of 3 and 4 cycles are rejected
    hold(3'b110, 3);
    hold(3'b100, 20);
    hold(3'b110, 4);
    hold(3'b100, 20);

    // 5-cycle hold is accepted: first step, clears stall, no period
    expect_ev(cyc + LAT, 3'b110, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    hold(3'b110, 200);

    // Forward rotation, 200 cycles per code
    foreach (fwd_codes[i]) begin
      expect_ev(cyc + LAT, fwd_codes[i], 1'b1, 1'b0, 1'b1, 16'd200, 1'b0, 1'b0);
      hold(fwd_codes[i], 200);
    end

    // Reverse 100 -> 101 -> 001
    expect_ev(cyc + LAT, 3'b101, 1'b1, 1'b1, 1'b1, 16'd200, 1'b0, 1'b0);
    hold(3'b101, 200);
    t_last = cyc + LAT;
    expect_ev(cyc + LAT, 3'b001, 1'b1, 1'b1, 1'b1, 16'd200, 1'b0, 1'b0);
    hold(3'b001, 200);

    // Invalid code and back: no steps, direction holds
    expect_ev(cyc + LAT, 3'b000, 1'b0, 1'b1, 1'b0, 16'd200, 1'b0, 1'b0);
    hold(3'b000, 50);
    expect_ev(cyc + LAT, 3'b001, 1'b0, 1'b1, 1'b0, 16'd200, 1'b0, 1'b0);
    // Stall when the cycle count since the last step reaches 1000
    expect_ev(t_last + 999, 3'b001, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    hold(3'b001, 800);

    // Step out of stall: stall clears, no period report
    expect_ev(cyc + LAT, 3'b101, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    hold(3'b101, 200);

    // Reverse chain back to 100
    foreach (rev_codes[i]) begin
      expect_ev(cyc + LAT, rev_codes[i], 1'b1, 1'b1, 1'b1, 16'd200, 1'b0, 1'b0);
      hold(rev_codes[i], 200);
    end

    // Non-adjacent jump 100 -> 010, then forward 010 -> 011
`ifdef HALL_SEQ_CHECK_EN
    expect_ev(cyc + LAT, 3'b010, 1'b0, 1'b1, 1'b0, 16'd200, 1'b0, 1'b1);
    hold(3'b010, 100);
    expect_ev(cyc + 1, 3'b010, 1'b0, 1'b1, 1'b0, 16'd200, 1'b0, 1'b0);
    seq_err_clr = 1'b1;
    @(posedge clk);
    #1;
    seq_err_clr = 1'b0;
    hold(3'b010, 99);
    // Jump did not restart the period count: 400 cycles since the 100 step
    expect_ev(cyc + LAT, 3'b011, 1'b1, 1'b0, 1'b1, 16'd400, 1'b0, 1'b0);
    hold(3'b011, 200);
`else
    expect_ev(cyc + LAT, 3'b010, 1'b1, 1'b1, 1'b1, 16'd200, 1'b0, 1'b0);
    hold(3'b010, 100);
    seq_err_clr = 1'b1;
    @(posedge clk);
    #1;
    seq_err_clr = 1'b0;
    chk("seq_err_tied", 32'(seq_err), 32'd0);
    hold(3'b010, 99);
    expect_ev(cyc + LAT, 3'b011, 1'b1, 1'b0, 1'b1, 16'd200, 1'b0, 1'b0);
    hold(3'b011, 200);
`endif

    // Drain with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: got nothing, want cyc=%0d code=%b step=%b period=%0d stalled=%b",
               e.cyc, e.code, e.step, e.period, e.stalled);
    end

    // Mid-operation asynchronous reset
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_reset_vals("midrst");
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
